// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and alignment check for the load/store sequencer.
package mem_access_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_WR,
    RESP
  } state_t;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lsb[0];
      SZ_WORD: misaligned = (lsb != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Load lane extract/extend and sub-word store merge on a 32-bit SRAM word.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rword,
  input  logic [15:0]       wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] merge_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v       = rword[{lane, 3'b000} +: 8];
    half_v       = rword[{lane[1], 4'b0000} +: 16];
    load_data_c  = rword;
    merge_data_c = rword;
    case (size)
      SZ_BYTE: begin
        load_data_c = {{24{is_signed & byte_v[7]}}, byte_v};
        merge_data_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data_c = {{16{is_signed & half_v[15]}}, half_v};
        merge_data_c[{lane[1], 4'b0000} +: 16] = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store sequencer in front of a word-only SRAM, with RMW for sub-word stores.
module mem_access_ctrl #(
  parameter int unsigned READ_WAIT = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout
);
  import mem_access_pkg::*;

  localparam int unsigned CNT_W = $clog2(READ_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lane_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [15:0]      wdata_q;
  logic             rmw_q;
  logic [31:0]      load_data_c;
  logic [31:0]      merge_data_c;

  // Formatting works directly on sram_dout so the response/merge word is registered on the capture edge.
  mem_lane_fmt u_fmt (
    .size         (size_q),
    .is_signed    (signed_q),
    .lane         (lane_q),
    .rword        (sram_dout),
    .wdata        (wdata_q),
    .load_data_c  (load_data_c),
    .merge_data_c (merge_data_c)
  );

  // Outputs are set on the edge that enters each state, so strobes never overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      rmw_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      sram_cs   <= 1'b0;
      sram_oe   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q    <= req_addr[1:0];
            size_q    <= req_size;
            signed_q  <= req_signed;
            wdata_q   <= req_wdata[15:0];
            rmw_q     <= 1'b0;
            cnt       <= '0;
            req_ready <= 1'b0;
            if (misaligned(req_size, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              sram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              sram_cs   <= 1'b1;
              if (req_we && (req_size == SZ_WORD)) begin
                state    <= WR;
                sram_we  <= 1'b1;
                sram_din <= req_wdata;
              end else begin
                state   <= RD;
                sram_oe <= 1'b1;
                rmw_q   <= req_we;
              end
            end
          end
        end
        RD: begin
          if (cnt == CNT_LAST) begin
            sram_oe <= 1'b0;
            if (rmw_q) begin
              state    <= RMW_WR;
              sram_we  <= 1'b1;
              sram_din <= merge_data_c;
            end else begin
              state     <= RESP;
              sram_cs   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data_c;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR, RMW_WR: begin
          state     <= RESP;
          sram_cs   <= 1'b0;
          sram_we   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: READ_WAIT=1 and READ_WAIT=3 instances share stimulus, each with its own SRAM model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic [1:0] rdy, rv, re, cs, oe, we;
  logic [1:0][31:0] rdata, addr, din, dout;

  logic [31:0] mem [2][256];
  int cs_cyc [2];
  int we_cyc [2];
  int rsp_cnt [2];
  int viol [2];
  logic [31:0] we_addr [2];
  logic [1:0] prev_cs;
  logic [1:0][31:0] prev_addr;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.READ_WAIT(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_err(re[0]), .rsp_rdata(rdata[0]), .sram_cs(cs[0]), .sram_oe(oe[0]),
    .sram_we(we[0]), .sram_addr(addr[0]), .sram_din(din[0]), .sram_dout(dout[0])
  );

  mem_access_ctrl #(.READ_WAIT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_err(re[1]), .rsp_rdata(rdata[1]), .sram_cs(cs[1]), .sram_oe(oe[1]),
    .sram_we(we[1]), .sram_addr(addr[1]), .sram_din(din[1]), .sram_dout(dout[1])
  );

  // SRAM models: synchronous write, combinational read while selected and output-enabled.
  assign dout[0] = (cs[0] && oe[0]) ? mem[0][addr[0][9:2]] : 32'h0;
  assign dout[1] = (cs[1] && oe[1]) ? mem[1][addr[1][9:2]] : 32'h0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (cs[i] && we[i]) mem[i][addr[i][9:2]] <= din[i];
  end

  // Bus activity counters and protocol rule tracking.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs[i]) cs_cyc[i] <= cs_cyc[i] + 1;
      if (cs[i] && we[i]) begin
        we_cyc[i]  <= we_cyc[i] + 1;
        we_addr[i] <= addr[i];
      end
      if (rv[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
      if ((we[i] && oe[i]) || (cs[i] && prev_cs[i] && (addr[i] !== prev_addr[i])))
        viol[i] <= viol[i] + 1;
      prev_cs[i]   <= cs[i];
      prev_addr[i] <= addr[i];
    end
  end

  task automatic issue(input string name, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic [31:0] e_data, input int lat1, input int lat3, input bit poke);
    logic [1:0] done;
    int c;
    int el;
    int rc0 [2];
    int cc0 [2];
    for (int i = 0; i < 2; i++) begin
      rc0[i] = rsp_cnt[i];
      cc0[i] = cs_cyc[i];
      vectors++;
      if (rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s ready[%0d]: got %b want 1", name, i, rdy[i]);
      end
    end
    req_we = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 1;
    done = 2'b00;
    while (done != 2'b11 && c <= 20) begin
      req_valid = (poke && c == 2);
      for (int i = 0; i < 2; i++) begin
        if (!done[i] && rv[i]) begin
          done[i] = 1'b1;
          el = (i == 0) ? lat1 : lat3;
          vectors += 3;
          if (c != el) begin
            errors++;
            $display("FAIL %s latency[%0d]: got %0d want %0d", name, i, c, el);
          end
          if (re[i] !== e_err) begin
            errors++;
            $display("FAIL %s err[%0d]: got %b want %b", name, i, re[i], e_err);
          end
          if (rdata[i] !== e_data) begin
            errors++;
            $display("FAIL %s rdata[%0d]: got %h want %h", name, i, rdata[i], e_data);
          end
        end
      end
      @(posedge clk); #1;
      c++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (!done[i]) begin
        errors++;
        $display("FAIL %s timeout[%0d]: no rsp_valid within 20 cycles", name, i);
      end
      vectors++;
      if (rsp_cnt[i] - rc0[i] != 1) begin
        errors++;
        $display("FAIL %s rsp_count[%0d]: got %0d want 1", name, i, rsp_cnt[i] - rc0[i]);
      end
      if (e_err) begin
        vectors++;
        if (cs_cyc[i] != cc0[i]) begin
          errors++;
          $display("FAIL %s cs_on_error[%0d]: got %0d cycles want 0", name, i, cs_cyc[i] - cc0[i]);
        end
      end
    end
  endtask

  task automatic check_mem(input string name, input logic [31:0] exp);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (mem[i][8'h40] !== exp) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %h want %h", name, i, mem[i][8'h40], exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({rdy[i], rv[i], re[i], cs[i], oe[i], we[i]} !== 6'b100000 || rdata[i] !== 32'h0 ||
          addr[i] !== 32'h0 || din[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got rdy/rv/err/cs/oe/we=%b%b%b%b%b%b rdata=%h addr=%h want 100000 0 0",
                 i, rdy[i], rv[i], re[i], cs[i], oe[i], we[i], rdata[i], addr[i]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int w0 [2];
    for (int i = 0; i < 2; i++) w0[i] = we_cyc[i];
    issue("word_store", 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 2, 2, 1'b0);
    check_mem("word_store", 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (we_cyc[i] - w0[i] != 1 || we_addr[i] !== 32'h100) begin
        errors++;
        $display("FAIL word_store_we[%0d]: got %0d pulses @%h want 1 @00000100", i, we_cyc[i] - w0[i], we_addr[i]);
      end
    end
    issue("word_load", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 2, 4, 1'b0);
  endtask

  task automatic test_subword_store();
    issue("byte_store", 1'b1, 2'b00, 1'b0, 32'h101, 32'h123456AA, 1'b0, 32'h0, 3, 5, 1'b0);
    check_mem("byte_store", 32'hDEADAAEF);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (we_addr[i] !== 32'h100) begin
        errors++;
        $display("FAIL byte_store_addr[%0d]: got %h want 00000100", i, we_addr[i]);
      end
    end
  endtask

  task automatic test_loads();
    issue("byte_load_s", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 4, 1'b0);
    issue("byte_load_u", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1'b0, 32'h000000AA, 2, 4, 1'b0);
    issue("half_load_s", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFFDEAD, 2, 4, 1'b0);
    issue("half_load_u", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0000AAEF, 2, 4, 1'b0);
    issue("half_store", 1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF1234, 1'b0, 32'h0, 3, 5, 1'b0);
    check_mem("half_store", 32'h1234AAEF);
    issue("byte_load_s3", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'h00000012, 2, 4, 1'b0);
    issue("byte_load_u0", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0, 32'h000000EF, 2, 4, 1'b0);
  endtask

  task automatic test_errors();
    issue("err_word_load", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 1, 1, 1'b0);
    issue("err_half_store", 1'b1, 2'b01, 1'b0, 32'h103, 32'h5555, 1'b1, 32'h0, 1, 1, 1'b0);
    issue("err_size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 1, 1'b0);
    issue("err_word_store", 1'b1, 2'b10, 1'b0, 32'h101, 32'hCAFEF00D, 1'b1, 32'h0, 1, 1, 1'b0);
    check_mem("err_no_write", 32'h1234AAEF);
  endtask

  task automatic test_busy();
    issue("busy_poke_load", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h1234AAEF, 2, 4, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rdy[i] !== 1'b1 || cs[i] !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle_after[%0d]: got rdy=%b cs=%b want rdy=1 cs=0", i, rdy[i], cs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc0 [2];
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100; req_wdata = '0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rc0[i] = rsp_cnt[i];
      vectors++;
      if (cs[i] !== 1'b1 || oe[i] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_in_rd[%0d]: got cs=%b oe=%b want 1 1", i, cs[i], oe[i]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({cs[i], oe[i], we[i], rv[i], rdy[i]} !== 5'b00001) begin
        errors++;
        $display("FAIL rst_mid_strobes[%0d]: got cs/oe/we/rv/rdy=%b%b%b%b%b want 00001",
                 i, cs[i], oe[i], we[i], rv[i], rdy[i]);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (rsp_cnt[i] != rc0[i] || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_no_rsp[%0d]: got %0d responses rdy=%b want 0 rdy=1", i, rsp_cnt[i] - rc0[i], rdy[i]);
      end
    end
    issue("load_after_rst", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h1234AAEF, 2, 4, 1'b0);
  endtask

  task automatic test_protocol();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (viol[i] != 0) begin
        errors++;
        $display("FAIL protocol[%0d]: got %0d we/oe overlap or addr-change cycles want 0", i, viol[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 256; j++) mem[i][j] = 32'h0;
      cs_cyc[i] = 0; we_cyc[i] = 0; rsp_cnt[i] = 0; viol[i] = 0; we_addr[i] = '0;
    end
    prev_cs = '0;
    prev_addr = '0;
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_errors();
    test_busy();
    test_reset_mid();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer directly upstream of the word-only data SRAM (sram_fix). It accepts byte, halfword and word requests from the datapath and drives the SRAM chip-select, output-enable, write-enable, address and data lines. It performs read-modify-write for sub-word stores, and does lane extraction plus sign or zero extension for loads. It returns one response per accepted request.

Parameters:
READ_WAIT, 1, cycles the SRAM address and oe are held before sram_dout is sampled (must be >= 1)
ADDR_W, 32, address width for both the request side and the SRAM side

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request strobe, sampled only when req_ready=1
req_ready  out  1  high in IDLE only
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error)
req_signed  in  1  load sign-extends when 1
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_err  out  1  qualifies rsp_valid; misaligned address or reserved size
rsp_rdata  out  32  extended load data; 0 for stores and errors
sram_cs  out  1  SRAM chip select
sram_oe  out  1  SRAM output enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}
sram_din  out  32  SRAM write data
sram_dout  in  32  SRAM read data

Behaviour:
- Reset: all outputs registered to 0, except req_ready, which goes to 1. State goes to IDLE and the wait counter clears.
- Reset mid-operation aborts the access. SRAM strobes are low on the cycle after the reset edge, and no response is produced.
- Byte lanes are little-endian: lane k occupies bits [8k+7:8k], selected by addr[1:0].
- Misalignment cases:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size = 11
- State IDLE: req_ready=1 and SRAM strobes are 0. On req_valid, latch addr, size, we, signed and wdata, then transition:
  - error case -> RESP with err=1, no SRAM access
  - load -> RD
  - word store -> WR
  - sub-word store -> RD with an rmw flag set
- State RD: cs=1, oe=1, we=0, sram_addr is held stable. The counter runs from 0 to READ_WAIT-1. On the last count, sram_dout is captured into rbuf. Next state is RMW_WR if the rmw flag is set, otherwise RESP.
- State WR: cs=1, we=1, oe=0, sram_din = wdata, for exactly one cycle, then RESP.
- State RMW_WR: same strobes as WR. sram_din = rbuf with the target byte or half lane replaced by wdata[7:0] or wdata[15:0]. Next state is RESP.
- State RESP: rsp_valid=1 for one cycle and strobes are 0.
  - Load: rsp_rdata = the selected lane, extended according to signed.
  - Otherwise: rsp_rdata = 0.
  - Next state is IDLE. A new request can be accepted on the following cycle.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - load: READ_WAIT+1
  - word store: 2
  - sub-word store: READ_WAIT+2
  - error: 1
- sram_we is never high in the same cycle as sram_oe. sram_addr does not change while cs=1. Both rules are needed because the SRAM model reacts to changes on we and addr.
- Counter width is $clog2(READ_WAIT+1).

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum IDLE, RD, WR, RMW_WR, RESP
  - misalignment function
- Sub-module mem_lane_fmt (combinational) performs the load lane extract/extend and the store lane merge.

Test Plan:
- Word store 0xDEADBEEF @0x100, then word load @0x100 -> one sram_we pulse with sram_addr=0x100; load response 0xDEADBEEF after 2 cycles.
- Byte store 0xAA @0x101 -> RD, then RMW_WR writes 0xDEADAAEF to 0x100; rsp_valid at READ_WAIT+2.
- Byte load @0x101: signed -> 0xFFFFFFAA, unsigned -> 0x000000AA. Half load signed @0x102 -> 0xFFFFDEAD.
- Misaligned word load @0x102 -> rsp_valid=1 and rsp_err=1 one cycle after accept, sram_cs never asserted.
- READ_WAIT=3: word load -> cs/oe held 3 cycles at a constant address, response at cycle 4. req_valid pulsed during busy is ignored, with no extra response.
- rst asserted during RD -> cs/oe low next cycle, no rsp_valid, req_ready=1 after reset.
